// File: rtl/shot_pkg.sv
// rtl/shot_pkg.sv - shared types and constants for the shot generator
//
// Holds the controller state enum, the fixed goal dimensions and the LFSR
// feedback tap mask plus its next-state helper.
package shot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AIM    = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_JUDGE  = 3'd3,
        ST_DONE   = 3'd4
    } shot_state_t;

    localparam int GOAL_W = 512;
    localparam int GOAL_H = 256;

    // Taps 16,14,13,11 -> bits 15,13,12,10 of the shift register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset, loads SEED
//   q    out  current register value, advances every clock
module lfsr16
    import shot_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/shot_ctl.sv
// rtl/shot_ctl.sv - solo-mode shot generator, ball animator and goal/save judge
//
// Ports:
//   clk                       in   system clock (pixel domain)
//   rst                       in   asynchronous active-low reset
//   vsync                     in   frame sync, rising edge = one frame tick
//   round_start               in   one-cycle request for a new shot
//   gloves_xpos/gloves_ypos   in   glove centre, sampled when judging
//   shot_xpos/shot_ypos       out  chosen target, held for the round
//   ball_xpos/ball_ypos       out  animated ball centre
//   ball_visible              out  draw-ball enable
//   is_scored                 out  round result, held until next round starts
//   round_done                out  one-cycle pulse when is_scored is valid
module shot_ctl
    import shot_pkg::*;
#(
    parameter int          GOAL_X_MIN  = 256,
    parameter int          GOAL_Y_MIN  = 160,
    parameter int          BALL_X0     = 512,
    parameter int          BALL_Y0     = 700,
    parameter int          FLIGHT_LOG2 = 6,
    parameter int          SAVE_RADIUS = 48,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        round_start,
    input  logic [11:0] gloves_xpos,
    input  logic [11:0] gloves_ypos,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos,
    output logic [11:0] ball_xpos,
    output logic [11:0] ball_ypos,
    output logic        ball_visible,
    output logic        is_scored,
    output logic        round_done
);

    // Product width: 13-bit signed delta times (FLIGHT_LOG2+1)-bit frame count.
    localparam int                 PW     = 14 + FLIGHT_LOG2;
    localparam logic [FLIGHT_LOG2:0] K_LAST = {1'b1, {FLIGHT_LOG2{1'b0}}};

    logic [15:0]          lfsr_q;
    logic                 vsync_q;
    shot_state_t          state_q;
    logic [FLIGHT_LOG2:0] k_q;
    logic [11:0]          shot_x_q, shot_y_q;
    logic [11:0]          ball_x_q, ball_y_q;
    logic                 visible_q, scored_q, done_q;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    logic                 tick;
    logic [FLIGHT_LOG2:0] k_d;
    logic [11:0]          shot_x_d, shot_y_d;
    logic signed [12:0]   dshot_x, dshot_y;
    logic signed [PW-1:0] prod_x, prod_y, step_x, step_y;
    logic [11:0]          ball_x_d, ball_y_d;
    logic signed [12:0]   dglove_x, dglove_y;
    logic [12:0]          adist_x, adist_y;
    logic                 saved;

    always_comb begin
        tick     = vsync & ~vsync_q;
        k_d      = k_q + 1'b1;

        // Target inside the goal: low LFSR bits span the width, high bits the height.
        shot_x_d = 12'(GOAL_X_MIN) + 12'(lfsr_q & 16'(GOAL_W - 1));
        shot_y_d = 12'(GOAL_Y_MIN) + 12'((lfsr_q >> 8) & 16'(GOAL_H - 1));

        // Linear interpolation from the spot using the frame count after this tick,
        // so the last tick lands exactly on the target.
        dshot_x  = $signed({1'b0, shot_x_q} - 13'(BALL_X0));
        dshot_y  = $signed({1'b0, shot_y_q} - 13'(BALL_Y0));
        prod_x   = PW'(dshot_x) * PW'($signed({1'b0, k_d}));
        prod_y   = PW'(dshot_y) * PW'($signed({1'b0, k_d}));
        step_x   = prod_x >>> FLIGHT_LOG2;
        step_y   = prod_y >>> FLIGHT_LOG2;
        ball_x_d = 12'(BALL_X0) + step_x[11:0];
        ball_y_d = 12'(BALL_Y0) + step_y[11:0];

        dglove_x = $signed({1'b0, gloves_xpos} - {1'b0, shot_x_q});
        dglove_y = $signed({1'b0, gloves_ypos} - {1'b0, shot_y_q});
        adist_x  = dglove_x[12] ? 13'(-dglove_x) : 13'(dglove_x);
        adist_y  = dglove_y[12] ? 13'(-dglove_y) : 13'(dglove_y);
        saved    = (adist_x <= 13'(SAVE_RADIUS)) && (adist_y <= 13'(SAVE_RADIUS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            vsync_q   <= 1'b0;
            k_q       <= '0;
            shot_x_q  <= '0;
            shot_y_q  <= '0;
            ball_x_q  <= 12'(BALL_X0);
            ball_y_q  <= 12'(BALL_Y0);
            visible_q <= 1'b0;
            scored_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (round_start) begin
                        state_q <= ST_AIM;
                    end
                end
                ST_AIM: begin
                    shot_x_q  <= shot_x_d;
                    shot_y_q  <= shot_y_d;
                    k_q       <= '0;
                    ball_x_q  <= 12'(BALL_X0);
                    ball_y_q  <= 12'(BALL_Y0);
                    visible_q <= 1'b1;
                    state_q   <= ST_FLIGHT;
                end
                ST_FLIGHT: begin
                    if (tick) begin
                        k_q      <= k_d;
                        ball_x_q <= ball_x_d;
                        ball_y_q <= ball_y_d;
                        if (k_d == K_LAST) begin
                            state_q <= ST_JUDGE;
                        end
                    end
                end
                ST_JUDGE: begin
                    scored_q <= ~saved;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (round_start) begin
                        scored_q  <= 1'b0;
                        visible_q <= 1'b0;
                        state_q   <= ST_AIM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign shot_xpos    = shot_x_q;
    assign shot_ypos    = shot_y_q;
    assign ball_xpos    = ball_x_q;
    assign ball_ypos    = ball_y_q;
    assign ball_visible = visible_q;
    assign is_scored    = scored_q;
    assign round_done   = done_q;

endmodule

// File: tb/tb_shot_ctl.sv
// tb/tb_shot_ctl.sv - scoreboard bench for shot_ctl
module tb_shot_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        round_start;
    logic [11:0] gloves_xpos, gloves_ypos;
    logic [11:0] shot_xpos, shot_ypos, ball_xpos, ball_ypos;
    logic        ball_visible, is_scored, round_done;

    shot_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .round_start  (round_start),
        .gloves_xpos  (gloves_xpos),
        .gloves_ypos  (gloves_ypos),
        .shot_xpos    (shot_xpos),
        .shot_ypos    (shot_ypos),
        .ball_xpos    (ball_xpos),
        .ball_ypos    (ball_ypos),
        .ball_visible (ball_visible),
        .is_scored    (is_scored),
        .round_done   (round_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tx;
        int ty;
        int scored;
    } exp_t;
    exp_t sb_q[$];

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int interp(input int p0, input int t, input int k);
        int p;
        p = ((t - p0) * k) >>> 6;
        return (p0 + p) & 12'hFFF;
    endfunction

    // Monitor: every round_done pops one expected round result.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (prev_done) chk("done_pulse_width", int'(round_done), 0);
            if (round_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected got round_done=1 expected no result pending");
                end else begin
                    e = sb_q.pop_front();
                    chk("done_is_scored", int'(is_scored), e.scored);
                    chk("done_shot_x", int'(shot_xpos), e.tx);
                    chk("done_shot_y", int'(shot_ypos), e.ty);
                    chk("done_ball_x", int'(ball_xpos), e.tx);
                    chk("done_ball_y", int'(ball_ypos), e.ty);
                    chk("done_visible", int'(ball_visible), 1);
                end
            end
            prev_done = round_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_round(output int tx, output int ty);
        logic [15:0] l;
        @(negedge clk);
        round_start = 1'b1;
        @(posedge clk);
        #1 l = lfsr_m;
        tx = 256 + int'(l[8:0]);
        ty = 160 + int'(l[15:8]);
        @(negedge clk);
        round_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int tx, ty;
        rst = 1'b0;
        vsync = 1'b0;
        round_start = 1'b0;
        gloves_xpos = '0;
        gloves_ypos = '0;
        repeat (3) @(negedge clk);
        chk("rst_ball_x", int'(ball_xpos), 512);
        chk("rst_ball_y", int'(ball_ypos), 700);
        chk("rst_shot_x", int'(shot_xpos), 0);
        chk("rst_visible", int'(ball_visible), 0);
        chk("rst_done", int'(round_done), 0);

        // Round 1: start straight out of reset; AIM sees LFSR 0x59C3 -> (707,249).
        // Gloves 49 px right of target: goal.
        rst = 1'b1;
        round_start = 1'b1;
        gloves_xpos = 12'd756;
        gloves_ypos = 12'd249;
        sb_q.push_back('{tx: 707, ty: 249, scored: 1});
        @(negedge clk);
        round_start = 1'b0;
        @(negedge clk);
        chk("r1_shot_x", int'(shot_xpos), 707);
        chk("r1_shot_y", int'(shot_ypos), 249);
        chk("r1_ball_x0", int'(ball_xpos), 512);
        chk("r1_ball_y0", int'(ball_ypos), 700);
        chk("r1_visible", int'(ball_visible), 1);
        for (int j = 1; j <= 64; j++) begin
            tick();
            if (j == 32) begin
                chk("r1_ball_x_k32", int'(ball_xpos), 609);
                chk("r1_ball_y_k32", int'(ball_ypos), 474);
            end
        end
        wait_drain("r1_result_timeout");
        chk("r1_scored_held", int'(is_scored), 1);

        // Round 2: start from DONE clears is_scored; gloves at exactly +48/-48: save.
        start_round(tx, ty);
        gloves_xpos = 12'(tx + 48);
        gloves_ypos = 12'(ty - 48);
        sb_q.push_back('{tx: tx, ty: ty, scored: 0});
        chk("r2_scored_cleared", int'(is_scored), 0);
        chk("r2_shot_x", int'(shot_xpos), tx);
        chk("r2_shot_y", int'(shot_ypos), ty);
        chk("r2_ball_x0", int'(ball_xpos), 512);
        // vsync held high for 100 clocks is a single frame tick.
        vsync = 1'b1;
        repeat (100) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        chk("r2_long_vsync_x", int'(ball_xpos), interp(512, tx, 1));
        chk("r2_long_vsync_y", int'(ball_ypos), interp(700, ty, 1));
        for (int j = 2; j <= 64; j++) begin
            tick();
            if (j == 10) begin
                @(negedge clk);
                round_start = 1'b1;
                @(negedge clk);
                round_start = 1'b0;
                @(negedge clk);
                chk("r2_ignored_shot_x", int'(shot_xpos), tx);
                chk("r2_ignored_shot_y", int'(shot_ypos), ty);
                chk("r2_ignored_ball_y", int'(ball_ypos), interp(700, ty, 10));
            end
            if (j == 11) begin
                chk("r2_k11_x", int'(ball_xpos), interp(512, tx, 11));
                chk("r2_k11_y", int'(ball_ypos), interp(700, ty, 11));
            end
        end
        wait_drain("r2_result_timeout");

        // Round 3: asynchronous reset mid-flight, no result must follow.
        start_round(tx, ty);
        repeat (5) tick();
        chk("r3_k5_y", int'(ball_ypos), interp(700, ty, 5));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r3_rst_ball_x", int'(ball_xpos), 512);
        chk("r3_rst_ball_y", int'(ball_ypos), 700);
        chk("r3_rst_visible", int'(ball_visible), 0);
        chk("r3_rst_scored", int'(is_scored), 0);
        chk("r3_rst_done", int'(round_done), 0);
        chk("r3_rst_shot_y", int'(shot_ypos), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        repeat (60) @(negedge clk);
        chk("r3_ball_parked_x", int'(ball_xpos), 512);
        chk("final_queue_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_ctl.md
# shot_ctl

Solo-mode shot generator and judge for the penalty game. On each round start it picks a pseudo-random target inside the goal and animates the ball frame by frame from the penalty spot to that target. When the ball arrives it compares the target with the goalkeeper-glove position and reports goal or save. It sits upstream of the gloves/ball drawing stages, which receive `shot_xpos`/`shot_ypos`/`ball_*`, and beside game_state_sel, which consumes `is_scored`/`round_done` and drives `round_start`.

## Interface
Parameters:
- `GOAL_X_MIN`, 256: left goal edge, px. Goal width is fixed at 512.
- `GOAL_Y_MIN`, 160: top goal edge, px. Goal height is fixed at 256.
- `BALL_X0`, 512: penalty-spot x.
- `BALL_Y0`, 700: penalty-spot y.
- `FLIGHT_LOG2`, 6: flight length is 2^FLIGHT_LOG2 frames (64).
- `SAVE_RADIUS`, 48: max per-axis glove/target distance for a save.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`  in  1  system clock (pixel domain).
- `rst`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  vsync from vga_timing. A rising edge is one frame tick.
- `round_start`  in  1  single-cycle pulse requesting a new shot.
- `gloves_xpos`, `gloves_ypos`  in  12 each  current glove centre.
- `shot_xpos`, `shot_ypos`  out  12 each  chosen target, held for the round.
- `ball_xpos`, `ball_ypos`  out  12 each  animated ball centre.
- `ball_visible`  out  1  draw-ball enable.
- `is_scored`  out  1  round result, held until the next round starts.
- `round_done`  out  1  one-cycle pulse when the result is valid.

## Operation
- States: IDLE, AIM, FLIGHT, JUDGE, DONE.
- **Reset:**
  - state = IDLE.
  - All outputs 0, except `ball_xpos`/`ball_ypos` = BALL_X0/BALL_Y0.
  - Frame counter k = 0; LFSR = LFSR_SEED.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. It advances every clock in every state, so the target depends on when the player clicks.
- **IDLE/DONE:** on `round_start` go to AIM. In DONE, this also clears `is_scored` and `ball_visible`.
- **AIM** (1 cycle):
  - `shot_xpos` = GOAL_X_MIN + lfsr[8:0].
  - `shot_ypos` = GOAL_Y_MIN + lfsr[15:8].
  - k = 0; ball = (BALL_X0, BALL_Y0); `ball_visible` = 1.
  - Next state: FLIGHT.
- **FLIGHT:** on each frame tick, k += 1 and the ball is updated:
  - ball_x = BALL_X0 + ((shot_x − BALL_X0)·k) >>> FLIGHT_LOG2
  - ball_y is computed the same way.
  - Arithmetic is 13-bit signed delta × 7-bit k, giving a 20-bit signed product, arithmetic shift, then truncate to 12 bits.
  - At k = 64 the ball equals the target exactly. Go to JUDGE.
- **JUDGE** (1 cycle):
  - Sample the gloves.
  - saved = (|gloves_x − shot_x| ≤ SAVE_RADIUS) AND (|gloves_y − shot_y| ≤ SAVE_RADIUS), using 13-bit signed differences.
  - `is_scored` = !saved; pulse `round_done`.
  - Next state: DONE.
- **Boundary cases:**
  - `round_start` in AIM/FLIGHT/JUDGE is ignored.
  - A frame tick coincident with `round_start` in DONE is ignored.
  - A distance exactly equal to SAVE_RADIUS counts as a save.
  - Async reset mid-flight returns to the reset values immediately. No `round_done` is emitted.

## Timing
- Edge detect: vsync is registered once. A tick is (vsync & !vsync_q), and is valid one cycle after vsync rises.
- `round_start` high at edge n:
  - AIM at n+1.
  - shot/ball/visible outputs valid after edge n+2.
- Ball outputs update on the edge after each tick. No combinational path from inputs to outputs.
- `round_done` is high exactly one cycle, starting after the edge that leaves JUDGE. `is_scored` is valid in that same cycle.
- Round latency = 64 frame ticks + 4 clocks, at most.

## Structure
- `shot_pkg` holds:
  - state enum `shot_state_t`;
  - goal width/height constants (512/256);
  - LFSR tap mask.
- Sub-module `lfsr16`: ports `clk`, `rst`, seed parameter, `q[15:0]`, free-running.
- The interpolation multiply is local to shot_ctl.

## Test plan
- **Reset:** assert `rst`=0 mid-FLIGHT → state IDLE, ball = (512,700), `ball_visible`/`is_scored`/`round_done` = 0 within the same cycle.
- **Target mapping:** force LFSR = 16'h1234 in AIM → `shot_xpos` = 256+0x034 = 308, `shot_ypos` = 160+0x12 = 178.
- **Interpolation:** target (768,160), 32 ticks → ball = (640,430). 64 ticks → ball = (768,160) exactly.
- **Save boundary:**
  - target (500,300), gloves (548,252) → `is_scored`=0.
  - gloves (549,300) → `is_scored`=1.
  - `round_done` is one cycle high in both cases.
- **Ignored requests:** `round_start` during FLIGHT → target unchanged, k continues. `round_start` in DONE → new AIM, `is_scored` cleared.
- **Tick detection:** vsync held high for 100 clocks → exactly one k increment.
